// File: rtl/mips_mc_controller_pkg.sv
// Shared encodings for the TinyMIPS multicycle controller: opcodes, function codes,
// ALU control codes, ALU operation classes and FSM states.
package mips_mc_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALUCONT_AND = 3'b000;
    localparam logic [2:0] ALUCONT_OR  = 3'b001;
    localparam logic [2:0] ALUCONT_ADD = 3'b010;
    localparam logic [2:0] ALUCONT_SUB = 3'b110;
    localparam logic [2:0] ALUCONT_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
    } state_t;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic       memtoreg;
        logic       iord;
        logic       regwrite;
        logic       regdst;
        logic       pcwrite;
        logic       pcwritecond;
        logic [1:0] pcsource;
        logic [1:0] alusrcb;
        logic [3:0] irwrite;
        aluop_t     aluop;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_controller_alu_decoder.sv
// Combinational ALU control decode: maps the FSM's operation class and the
// instruction funct field onto the 3-bit ALU control code.
module mips_mc_controller_alu_decoder
    import mips_mc_controller_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucont
);

    // Unknown funct values fall back to add so the datapath never sees an undefined code.
    always_comb begin
        alucont = ALUCONT_ADD;
        case (aluop)
            ALUOP_ADD: alucont = ALUCONT_ADD;
            ALUOP_SUB: alucont = ALUCONT_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucont = ALUCONT_ADD;
                    FUNCT_SUB: alucont = ALUCONT_SUB;
                    FUNCT_AND: alucont = ALUCONT_AND;
                    FUNCT_OR:  alucont = ALUCONT_OR;
                    FUNCT_SLT: alucont = ALUCONT_SLT;
                    default:   alucont = ALUCONT_ADD;
                endcase
            end
            default: alucont = ALUCONT_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle Moore control FSM for the 8-bit TinyMIPS datapath: byte-wise fetch,
// decode, execute, memory access and writeback for lb/sb/R-type/beq/j/addi.
module mips_mc_controller
    import mips_mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic       memtoreg,
    output logic       iord,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic [1:0] pcsource,
    output logic [1:0] alusrcb,
    output logic [3:0] irwrite,
    output logic [2:0] alucont
);

    state_t     state_q, state_d;
    ctrl_t      ctrl;
    logic [2:0] alucont_raw;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH1;
        else       state_q <= state_d;
    end

    always_comb begin
        ctrl       = '0;
        ctrl.aluop = ALUOP_ADD;
        state_d    = FETCH1;
        case (state_q)
            FETCH1: begin
                ctrl.memread = 1'b1; ctrl.alusrcb = 2'b01; ctrl.pcwrite = 1'b1;
                ctrl.irwrite = 4'b0001; state_d = FETCH2;
            end
            FETCH2: begin
                ctrl.memread = 1'b1; ctrl.alusrcb = 2'b01; ctrl.pcwrite = 1'b1;
                ctrl.irwrite = 4'b0010; state_d = FETCH3;
            end
            FETCH3: begin
                ctrl.memread = 1'b1; ctrl.alusrcb = 2'b01; ctrl.pcwrite = 1'b1;
                ctrl.irwrite = 4'b0100; state_d = FETCH4;
            end
            FETCH4: begin
                ctrl.memread = 1'b1; ctrl.alusrcb = 2'b01; ctrl.pcwrite = 1'b1;
                ctrl.irwrite = 4'b1000; state_d = DECODE;
            end
            DECODE: begin
                ctrl.alusrcb = 2'b11;
                case (op)
                    OP_LB, OP_SB: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = FETCH1;
                endcase
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1; ctrl.alusrcb = 2'b10;
                if (op == OP_LB)      state_d = LBRD;
                else if (op == OP_SB) state_d = SBWR;
                else                  state_d = FETCH1;
            end
            LBRD: begin
                ctrl.memread = 1'b1; ctrl.iord = 1'b1; state_d = LBWR;
            end
            LBWR: begin
                ctrl.regwrite = 1'b1; ctrl.memtoreg = 1'b1;
            end
            SBWR: begin
                ctrl.memwrite = 1'b1; ctrl.iord = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1; ctrl.aluop = ALUOP_FUNCT; state_d = RTYPEWR;
            end
            RTYPEWR: begin
                ctrl.regdst = 1'b1; ctrl.regwrite = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1; ctrl.aluop = ALUOP_SUB;
                ctrl.pcsource = 2'b01; ctrl.pcwritecond = 1'b1;
            end
            JEX: begin
                ctrl.pcsource = 2'b10; ctrl.pcwrite = 1'b1;
            end
            ADDIEX: begin
                ctrl.alusrca = 1'b1; ctrl.alusrcb = 2'b10; state_d = ADDIWR;
            end
            ADDIWR: begin
                ctrl.regwrite = 1'b1;
            end
            default: state_d = FETCH1;
        endcase
    end

    mips_mc_controller_alu_decoder u_alu_decoder (
        .aluop   (ctrl.aluop),
        .funct   (funct),
        .alucont (alucont_raw)
    );

    // Reset masks every strobe so an aborted instruction cannot write on the reset cycle.
    assign memread  = ctrl.memread  & ~reset;
    assign memwrite = ctrl.memwrite & ~reset;
    assign alusrca  = ctrl.alusrca  & ~reset;
    assign memtoreg = ctrl.memtoreg & ~reset;
    assign iord     = ctrl.iord     & ~reset;
    assign regwrite = ctrl.regwrite & ~reset;
    assign regdst   = ctrl.regdst   & ~reset;
    assign pcsource = reset ? 2'b00   : ctrl.pcsource;
    assign alusrcb  = reset ? 2'b00   : ctrl.alusrcb;
    assign irwrite  = reset ? 4'b0000 : ctrl.irwrite;
    assign alucont  = reset ? 3'b000  : alucont_raw;
    assign pcen     = ~reset & (ctrl.pcwrite | (ctrl.pcwritecond & zero));

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for the TinyMIPS multicycle controller: stimulus pushes the
// hand-derived expected output word per cycle, a negedge monitor pops and compares.
module tb_mips_mc_controller;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic       memtoreg;
        logic       iord;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic [1:0] pcsource;
        logic [1:0] alusrcb;
        logic [3:0] irwrite;
        logic [2:0] alucont;
    } out_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_entry_t;

    localparam int S_RST   = 0;
    localparam int S_F1    = 1;
    localparam int S_F2    = 2;
    localparam int S_F3    = 3;
    localparam int S_F4    = 4;
    localparam int S_DEC   = 5;
    localparam int S_MADR  = 6;
    localparam int S_LBRD  = 7;
    localparam int S_LBWR  = 8;
    localparam int S_SBWR  = 9;
    localparam int S_RTEX  = 10;
    localparam int S_RTWR  = 11;
    localparam int S_BEQ   = 12;
    localparam int S_JEX   = 13;
    localparam int S_ADEX  = 14;
    localparam int S_ADWR  = 15;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst;
    logic [1:0] pcsource, alusrcb;
    logic [3:0] irwrite;
    logic [2:0] alucont;
    out_t       act;

    sb_entry_t sb_q[$];
    int        checks = 0;
    int        errors = 0;

    mips_mc_controller dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .memread  (memread),
        .memwrite (memwrite),
        .alusrca  (alusrca),
        .memtoreg (memtoreg),
        .iord     (iord),
        .pcen     (pcen),
        .regwrite (regwrite),
        .regdst   (regdst),
        .pcsource (pcsource),
        .alusrcb  (alusrcb),
        .irwrite  (irwrite),
        .alucont  (alucont)
    );

    assign act = {memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst,
                  pcsource, alusrcb, irwrite, alucont};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs per state, written out from the control table by hand.
    function automatic out_t expectFor(input int st, input logic z, input logic [5:0] fn);
        out_t e;
        e = '0;
        e.alucont = 3'b010;
        case (st)
            S_RST: e.alucont = 3'b000;
            S_F1:  begin e.memread = 1; e.alusrcb = 2'b01; e.pcen = 1; e.irwrite = 4'b0001; end
            S_F2:  begin e.memread = 1; e.alusrcb = 2'b01; e.pcen = 1; e.irwrite = 4'b0010; end
            S_F3:  begin e.memread = 1; e.alusrcb = 2'b01; e.pcen = 1; e.irwrite = 4'b0100; end
            S_F4:  begin e.memread = 1; e.alusrcb = 2'b01; e.pcen = 1; e.irwrite = 4'b1000; end
            S_DEC: e.alusrcb = 2'b11;
            S_MADR: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            S_LBRD: begin e.memread = 1; e.iord = 1; end
            S_LBWR: begin e.regwrite = 1; e.memtoreg = 1; end
            S_SBWR: begin e.memwrite = 1; e.iord = 1; end
            S_RTEX: begin
                e.alusrca = 1;
                case (fn)
                    6'b100010: e.alucont = 3'b110;
                    6'b100100: e.alucont = 3'b000;
                    6'b100101: e.alucont = 3'b001;
                    6'b101010: e.alucont = 3'b111;
                    default:   e.alucont = 3'b010;
                endcase
            end
            S_RTWR: begin e.regdst = 1; e.regwrite = 1; end
            S_BEQ:  begin e.alusrca = 1; e.alucont = 3'b110; e.pcsource = 2'b01; e.pcen = z; end
            S_JEX:  begin e.pcsource = 2'b10; e.pcen = 1; end
            S_ADEX: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            S_ADWR: e.regwrite = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic applyStimulus(input string name, input logic rst, input logic [5:0] op_i,
                                 input logic [5:0] fn_i, input logic z_i, input int st);
        sb_entry_t ent;
        reset = rst;
        op    = op_i;
        funct = fn_i;
        zero  = z_i;
        ent.name = name;
        ent.exp  = expectFor(st, z_i, fn_i);
        sb_q.push_back(ent);
        @(posedge clk);
        #1;
    endtask

    task automatic fetchDecode(input string tag, input logic [5:0] op_i,
                               input logic [5:0] fn_i, input logic z_i);
        applyStimulus({tag, "_fetch1"}, 1'b0, op_i, fn_i, z_i, S_F1);
        applyStimulus({tag, "_fetch2"}, 1'b0, op_i, fn_i, z_i, S_F2);
        applyStimulus({tag, "_fetch3"}, 1'b0, op_i, fn_i, z_i, S_F3);
        applyStimulus({tag, "_fetch4"}, 1'b0, op_i, fn_i, z_i, S_F4);
        applyStimulus({tag, "_decode"}, 1'b0, op_i, fn_i, z_i, S_DEC);
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got mr=%b mw=%b asa=%b m2r=%b iord=%b pcen=%b rw=%b rd=%b pcs=%b asb=%b ir=%b ac=%b, wanted %b",
                     name, act.memread, act.memwrite, act.alusrca, act.memtoreg, act.iord,
                     act.pcen, act.regwrite, act.regdst, act.pcsource, act.alusrcb,
                     act.irwrite, act.alucont, exp);
        end
    endtask

    // Monitor: one expected word is outstanding per cycle; compare away from the edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_entry_t ent;
            ent = sb_q.pop_front();
            checkOutput(ent.name, ent.exp);
        end
    end

    initial begin
        int wait_cycles;
        reset = 1'b1;
        op    = 6'b000000;
        funct = 6'b100000;
        zero  = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus("reset0", 1'b1, 6'b000000, 6'b100000, 1'b0, S_RST);
        applyStimulus("reset1", 1'b1, 6'b000000, 6'b100000, 1'b0, S_RST);

        fetchDecode("radd", 6'b000000, 6'b100000, 1'b1);
        applyStimulus("radd_ex", 1'b0, 6'b000000, 6'b100000, 1'b1, S_RTEX);
        applyStimulus("radd_wr", 1'b0, 6'b000000, 6'b100000, 1'b1, S_RTWR);

        fetchDecode("lb", 6'b100000, 6'b000111, 1'b0);
        applyStimulus("lb_memadr", 1'b0, 6'b100000, 6'b000111, 1'b0, S_MADR);
        applyStimulus("lb_rd",     1'b0, 6'b100000, 6'b000111, 1'b0, S_LBRD);
        applyStimulus("lb_wr",     1'b0, 6'b100000, 6'b000111, 1'b0, S_LBWR);

        fetchDecode("sb", 6'b101000, 6'b000011, 1'b1);
        applyStimulus("sb_memadr", 1'b0, 6'b101000, 6'b000011, 1'b1, S_MADR);
        applyStimulus("sb_wr",     1'b0, 6'b101000, 6'b000011, 1'b1, S_SBWR);

        fetchDecode("beqz1", 6'b000100, 6'b000000, 1'b1);
        applyStimulus("beqz1_ex", 1'b0, 6'b000100, 6'b000000, 1'b1, S_BEQ);
        fetchDecode("beqz0", 6'b000100, 6'b000000, 1'b0);
        applyStimulus("beqz0_ex", 1'b0, 6'b000100, 6'b000000, 1'b0, S_BEQ);

        fetchDecode("j", 6'b000010, 6'b010101, 1'b0);
        applyStimulus("j_ex", 1'b0, 6'b000010, 6'b010101, 1'b0, S_JEX);

        fetchDecode("addi", 6'b001000, 6'b000101, 1'b0);
        applyStimulus("addi_ex", 1'b0, 6'b001000, 6'b000101, 1'b0, S_ADEX);
        applyStimulus("addi_wr", 1'b0, 6'b001000, 6'b000101, 1'b0, S_ADWR);

        fetchDecode("rsub", 6'b000000, 6'b100010, 1'b0);
        applyStimulus("rsub_ex", 1'b0, 6'b000000, 6'b100010, 1'b0, S_RTEX);
        applyStimulus("rsub_wr", 1'b0, 6'b000000, 6'b100010, 1'b0, S_RTWR);
        fetchDecode("rand", 6'b000000, 6'b100100, 1'b0);
        applyStimulus("rand_ex", 1'b0, 6'b000000, 6'b100100, 1'b0, S_RTEX);
        applyStimulus("rand_wr", 1'b0, 6'b000000, 6'b100100, 1'b0, S_RTWR);
        fetchDecode("ror", 6'b000000, 6'b100101, 1'b0);
        applyStimulus("ror_ex", 1'b0, 6'b000000, 6'b100101, 1'b0, S_RTEX);
        applyStimulus("ror_wr", 1'b0, 6'b000000, 6'b100101, 1'b0, S_RTWR);
        fetchDecode("rslt", 6'b000000, 6'b101010, 1'b0);
        applyStimulus("rslt_ex", 1'b0, 6'b000000, 6'b101010, 1'b0, S_RTEX);
        applyStimulus("rslt_wr", 1'b0, 6'b000000, 6'b101010, 1'b0, S_RTWR);
        fetchDecode("runk", 6'b000000, 6'b110011, 1'b0);
        applyStimulus("runk_ex", 1'b0, 6'b000000, 6'b110011, 1'b0, S_RTEX);
        applyStimulus("runk_wr", 1'b0, 6'b000000, 6'b110011, 1'b0, S_RTWR);

        fetchDecode("illegal", 6'b111111, 6'b000000, 1'b1);

        fetchDecode("abort", 6'b000000, 6'b100000, 1'b0);
        applyStimulus("abort_reset", 1'b1, 6'b000000, 6'b100000, 1'b0, S_RST);
        applyStimulus("abort_fetch1", 1'b0, 6'b000000, 6'b100000, 1'b0, S_F1);
        applyStimulus("abort_fetch2", 1'b0, 6'b000000, 6'b100000, 1'b0, S_F2);

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d entries left, wanted 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
